// File: rtl/cpu_seq_if.sv
// cpu_seq_if: instruction handshake and decode bus of the cpu_seq sequencer.
//   master modport: instruction source (drives instr/instr_valid, observes the rest)
//   slave  modport: cpu_seq itself
//   instr[15:0], instr_valid, instr_ready       -- instruction handshake
//   add_sub_mode, reg_raddr1/2, imm_sel, imm,
//   ld_imm, reg_we, reg_waddr                    -- ALU / register-file control
//   busy, halted, illegal, retired[15:0]         -- status
interface cpu_seq_if #(
  parameter int DATA_W = 8
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              add_sub_mode;
  logic [3:0]        reg_raddr1;
  logic [3:0]        reg_raddr2;
  logic              imm_sel;
  logic [DATA_W-1:0] imm;
  logic              ld_imm;
  logic              reg_we;
  logic [3:0]        reg_waddr;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic [15:0]       retired;

  modport master (
    output instr, instr_valid,
    input  instr_ready, add_sub_mode, reg_raddr1, reg_raddr2, imm_sel, imm,
           ld_imm, reg_we, reg_waddr, busy, halted, illegal, retired
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, add_sub_mode, reg_raddr1, reg_raddr2, imm_sel, imm,
           ld_imm, reg_we, reg_waddr, busy, halted, illegal, retired
  );
endinterface

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer in front of the add/sub ALU.
// Accepts one 16-bit instruction in IDLE, then walks DECODE -> EXEC -> WB
// (NOP and, in the default build, illegal opcodes return to IDLE from DECODE;
// HALT parks in HALT until reset).
// Ports:
//   clk  -- clock, rising edge
//   rst  -- asynchronous active-high reset
//   bus  -- cpu_seq_if.slave: instr/instr_valid in; instr_ready, ALU mode,
//           register addresses, immediate path, write strobe and status out
// Parameter DATA_W: width of the immediate output (imm8 zero-extended/truncated).
// Build option: define CPU_SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes
// (sticky illegal flag + HALT); otherwise they execute as NOP.
module cpu_seq #(
  parameter int DATA_W = 8
) (
  input logic      clk,
  input logic      rst,
  cpu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_ADDI = 4'h3,
    OP_LI   = 4'h4,
    OP_HALT = 4'hF
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q;
  logic        accept;
  logic        retire;
  logic [15:0] retired_q;
  logic [3:0]  in_op, in_rd, in_rs1, in_rs2;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic trap;
  logic illegal_q;
`endif

  assign in_op  = bus.instr[15:12];
  assign in_rd  = bus.instr[11:8];
  assign in_rs1 = bus.instr[7:4];
  assign in_rs2 = bus.instr[3:0];

  assign accept = (state_q == S_IDLE) && bus.instr_valid;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    trap    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_q)
          OP_NOP: begin
            state_d = S_IDLE;
            retire  = 1'b1;
          end
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          OP_ADD, OP_SUB, OP_ADDI, OP_LI: begin
            state_d = S_EXEC;
          end
          default: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            state_d = S_HALT;
            trap    = 1'b1;
`else
            state_d = S_IDLE;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC: begin
        // Count on entry to WB so retired moves together with the reg_we strobe.
        state_d = S_WB;
        retire  = 1'b1;
      end
      S_WB:    state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Status and strobe outputs are registered from the next state, so each one
  // is a clean flop output that matches the state the block is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr_ready <= 1'b1;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.reg_we      <= 1'b0;
      retired_q       <= '0;
    end else begin
      bus.instr_ready <= (state_d == S_IDLE);
      bus.busy        <= (state_d != S_IDLE);
      bus.halted      <= (state_d == S_HALT);
      bus.reg_we      <= (state_d == S_WB);
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  // Decode outputs load straight from the instruction word at accept and hold
  // until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q             <= OP_NOP;
      bus.reg_raddr1   <= '0;
      bus.reg_raddr2   <= '0;
      bus.reg_waddr    <= '0;
      bus.add_sub_mode <= 1'b1;
      bus.imm_sel      <= 1'b0;
      bus.ld_imm       <= 1'b0;
      bus.imm          <= '0;
    end else if (accept) begin
      op_q             <= op_e'(in_op);
      bus.reg_raddr1   <= (in_op == OP_ADDI) ? in_rd : in_rs1;
      bus.reg_raddr2   <= in_rs2;
      bus.reg_waddr    <= in_rd;
      bus.add_sub_mode <= (in_op != OP_SUB);
      bus.imm_sel      <= (in_op == OP_ADDI);
      bus.ld_imm       <= (in_op == OP_LI);
      bus.imm          <= DATA_W'(bus.instr[7:0]);
    end
  end

  assign bus.retired = retired_q;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule
